// File: rtl/counter_pkg.sv
// Shared encodings for the up/down counter: direction and bound-handling mode.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated prescaler: emits a tick on every (prescale+1)-th enabled cycle.
module tick_prescaler #(
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt;

    assign tick = en && (cnt == prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == prescale) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable modulus and step, wrap or saturate at bounds,
// prescaled enable, synchronous load, terminal-count pulse and sticky ovf/udf flags.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH       = 32,
    parameter int unsigned     STEP_W      = 8,   // must not exceed WIDTH
    parameter int unsigned     PRESCALE_W  = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  up_not_down,
    input  logic [STEP_W-1:0]     step,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  sat_mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  clr_flags,
    output logic [WIDTH-1:0]      out_value,
    output logic                  tc,
    output logic                  ovf,
    output logic                  udf
);

    logic             tick;
    logic             tick_go;
    logic             bound_evt;
    logic [WIDTH:0]   s_x, out_x, lim_x, lim1_x, sum_x, nxt_x;
    logic [WIDTH-1:0] next_value;
    logic [WIDTH-1:0] load_clamped;

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (load),
        .prescale (prescale),
        .tick     (tick)
    );

    assign tick_go      = tick && !load;
    assign load_clamped = (load_value > limit) ? limit : load_value;

    // All arithmetic is one bit wider than the counter so sums never truncate.
    always_comb begin
        s_x       = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
        out_x     = {1'b0, out_value};
        lim_x     = {1'b0, limit};
        lim1_x    = lim_x + 1'b1;
        sum_x     = out_x + s_x;
        nxt_x     = out_x;
        bound_evt = 1'b0;
        if (up_not_down == DIR_UP) begin
            if (sum_x <= lim_x) begin
                nxt_x = sum_x;
            end else begin
                bound_evt = 1'b1;
                if (sat_mode == MODE_SAT) begin
                    nxt_x = lim_x;
                end else begin
                    nxt_x = sum_x - lim1_x;
                    if (nxt_x > lim_x) nxt_x = lim_x;
                end
            end
            if (sat_mode == MODE_SAT && nxt_x == lim_x) bound_evt = 1'b1;
        end else begin
            if (s_x <= out_x) begin
                nxt_x = out_x - s_x;
            end else begin
                bound_evt = 1'b1;
                if (sat_mode == MODE_SAT) begin
                    nxt_x = '0;
                end else begin
                    nxt_x = out_x + lim1_x - s_x;
                    if (nxt_x > lim_x) nxt_x = lim_x;
                end
            end
            if (sat_mode == MODE_SAT && nxt_x == '0) bound_evt = 1'b1;
        end
        // A zero step is a no-op tick, even when out_value sits above a lowered limit.
        if (step == '0) begin
            nxt_x     = out_x;
            bound_evt = 1'b0;
        end
        next_value = nxt_x[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_value <= RESET_VALUE;
            tc        <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                out_value <= load_clamped;
            end else if (tick) begin
                out_value <= next_value;
                tc        <= bound_evt;
            end
        end
    end

    // Flag set takes priority over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (tick_go && bound_evt && up_not_down == DIR_UP) begin
                ovf <= 1'b1;
            end else if (clr_flags) begin
                ovf <= 1'b0;
            end
            if (tick_go && bound_evt && up_not_down == DIR_DOWN) begin
                udf <= 1'b1;
            end else if (clr_flags) begin
                udf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod at WIDTH=8 with hand-computed expectations.
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] load_value;
    logic       up_not_down;
    logic [7:0] step;
    logic [7:0] limit;
    logic       sat_mode;
    logic [7:0] prescale;
    logic       clr_flags;
    logic [7:0] out_value;
    logic       tc;
    logic       ovf;
    logic       udf;

    int n_cmp = 0;
    int n_bad = 0;

    updown_counter_mod #(
        .WIDTH       (8),
        .STEP_W      (8),
        .PRESCALE_W  (8),
        .RESET_VALUE (8'd0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .load_value  (load_value),
        .up_not_down (up_not_down),
        .step        (step),
        .limit       (limit),
        .sat_mode    (sat_mode),
        .prescale    (prescale),
        .clr_flags   (clr_flags),
        .out_value   (out_value),
        .tc          (tc),
        .ovf         (ovf),
        .udf         (udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_out, input logic e_tc,
                             input logic e_ovf, input logic e_udf);
        check({tag, ".out"}, {24'd0, out_value}, {24'd0, e_out});
        check({tag, ".tc"},  {31'd0, tc},  {31'd0, e_tc});
        check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, e_ovf});
        check({tag, ".udf"}, {31'd0, udf}, {31'd0, e_udf});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b0; load_value = 8'd0; up_not_down = 1'b1;
        step = 8'd1; limit = 8'd9; sat_mode = 1'b0; prescale = 8'd0; clr_flags = 1'b0;
        #3;
        check_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
        #4 rst = 1'b0;
        #1;

        // 1: mod-10 up counter, wrap at 9 -> 0
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check_all($sformatf("t1.k%0d", k), 8'(k % 10), k == 10, k >= 10, 1'b0);
        end

        // 2: down wrap from 2 by 3 within 0..9
        en = 1'b0; clr_flags = 1'b1;
        cyc();
        check_all("t2.clr", 8'd2, 1'b0, 1'b0, 1'b0);
        clr_flags = 1'b0; load = 1'b1; load_value = 8'd2; step = 8'd3; up_not_down = 1'b0;
        cyc();
        check_all("t2.load", 8'd2, 1'b0, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        cyc();
        check_all("t2.tick", 8'd9, 1'b1, 1'b0, 1'b1);
        en = 1'b0;
        cyc();
        check_all("t2.hold", 8'd9, 1'b0, 1'b0, 1'b1);

        // 3: saturate at 200, tc on every tick
        clr_flags = 1'b1; load = 1'b1; load_value = 8'd180; limit = 8'd200;
        sat_mode = 1'b1; up_not_down = 1'b1; step = 8'd50;
        cyc();
        check_all("t3.load", 8'd180, 1'b0, 1'b0, 1'b0);
        clr_flags = 1'b0; load = 1'b0; en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            check_all($sformatf("t3.k%0d", k), 8'd200, 1'b1, 1'b1, 1'b0);
        end

        // 4: prescale=3 -> one increment per 4 enabled cycles
        en = 1'b0; clr_flags = 1'b1; load = 1'b1; load_value = 8'd0; limit = 8'd100;
        sat_mode = 1'b0; step = 8'd1; prescale = 8'd3;
        cyc();
        check_all("t4.load", 8'd0, 1'b0, 1'b0, 1'b0);
        clr_flags = 1'b0; load = 1'b0; en = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            check($sformatf("t4.c%0d", c), {24'd0, out_value}, (c / 4));
        end
        cyc();
        cyc();
        check("t4.pre_gap", {24'd0, out_value}, 32'd2);
        en = 1'b0;
        cyc();
        cyc();
        check("t4.gap", {24'd0, out_value}, 32'd2);
        en = 1'b1;
        cyc();
        check("t4.post_gap1", {24'd0, out_value}, 32'd2);
        cyc();
        check("t4.post_gap2", {24'd0, out_value}, 32'd3);

        // 5: load beats a pending tick and clamps; flag set beats same-edge clear
        prescale = 8'd0; load = 1'b1; load_value = 8'd250;
        cyc();
        check_all("t5.load", 8'd100, 1'b0, 1'b0, 1'b0);
        load = 1'b0; clr_flags = 1'b1;
        cyc();
        check_all("t5.set_clr", 8'd0, 1'b1, 1'b1, 1'b0);
        en = 1'b0;
        cyc();
        check_all("t5.clr", 8'd0, 1'b0, 1'b0, 1'b0);

        // 6: asynchronous reset between edges
        clr_flags = 1'b0; load = 1'b1; load_value = 8'd99; step = 8'd3;
        cyc();
        load = 1'b0; en = 1'b1;
        cyc();
        check_all("t6.pre", 8'd1, 1'b1, 1'b1, 1'b0);
        #3 rst = 1'b1;
        #1;
        check_all("t6.rst", 8'd0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        cyc();
        check_all("t6.resume", 8'd3, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
